multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle decoding with a per-instruction state machine so that instruction fetch and data access share one memory port. It drives the same control-signal set as the combinational control unit, plus PC and IR write enables, memory handshake and address select. It also counts retired instructions and halts on illegal opcodes or memory timeouts.

## Interface
- TIMEOUT, 16: consecutive wait cycles without `mem_ready` before a bus error (range 2..255).
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0], stable from the DECODE state onward
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until `mem_ready`
- iord  out  1  memory address select: 0 = PC, 1 = ALU result
- mem_read_en  out  1  read request
- mem_write_en  out  1  write request
- ir_write_en  out  1  latch IR and old PC
- pc_write_en  out  1  PC update
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch/jump target
- reg_write_en  out  1  register file write
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU/link
- alu_src  out  1  ALU operand B: 1 = immediate, 0 = rs2
- alu_op  out  2  00 R-type/JAL, 01 I/load/store, 10 branch
- jump  out  1  JAL in progress
- branch  out  1  branch in progress
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction
- retired_count  out  CNT_W  count of retired instructions; wraps
- halted  out  1  controller is in HALT
- illegal_op  out  1  sticky; set on an unknown opcode
- bus_err  out  1  sticky; set on a memory timeout

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters FETCH.
- All control outputs are decoded from state, `opcode`, `zero` and `mem_ready`. Unlisted outputs are 0.
- FETCH
  - Outputs: mem_req=1, mem_read_en=1, iord=0.
  - On `mem_ready`: ir_write_en=1, pc_write_en=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE
  - One cycle, used for operand read.
  - Opcodes 0110011, 0010011, 0000011, 0100011, 1100011 and 1101111 go to EXEC.
  - Any other opcode goes to HALT and sets `illegal_op`.
- EXEC
  - R-type (0110011): alu_src=0, alu_op=00, then WB.
  - I-type (0010011): alu_src=1, alu_op=01, then WB.
  - Load (0000011) and store (0100011): alu_src=1, alu_op=01, then MEM.
  - Branch (1100011): branch=1, alu_op=10, pc_src=1, pc_write_en=zero. Retires, then FETCH.
  - JAL (1101111): jump=1, pc_src=1, pc_write_en=1, reg_write_en=1. Retires, then FETCH.
- MEM
  - Outputs: mem_req=1, iord=1, alu_op=01, alu_src=1.
  - Load asserts mem_read_en; store asserts mem_write_en.
  - On `mem_ready`: a load goes to WB; a store retires and goes to FETCH.
- WB
  - Outputs: reg_write_en=1; mem_to_reg=1 for a load, 0 otherwise.
  - Retires, then FETCH.
- HALT
  - All control outputs are 0; halted=1.
  - Leaves only on `rst`.
- Retirement
  - `instr_retired` pulses in the retiring cycle.
  - `retired_count` increments by 1 on the following edge and wraps from all-ones to 0.
- Timeout
  - A wait counter clears on every state entry and counts FETCH/MEM cycles with `mem_ready`=0.
  - When it reaches TIMEOUT, the controller goes to HALT and sets `bus_err`. No retire, no write.
  - If `mem_ready` arrives on the cycle the counter would reach TIMEOUT, `mem_ready` wins and the transfer completes.
- Handshake
  - `mem_req` and its address/enable outputs stay constant while waiting.
  - `mem_ready` is ignored when `mem_req`=0.

## Timing
- Reset
  - `rst` high at an edge: state=FETCH, retired_count=0, illegal_op=0, bus_err=0, wait counter=0.
  - All outputs are 0 while `rst` is high, including `mem_req`.
  - Reset mid-instruction or in HALT abandons the instruction with no retire. Fetch restarts in the cycle after `rst` falls.
- Latency with zero wait states:
  - R-type, I-type, store: 4 cycles.
  - Load: 5 cycles.
  - Branch, JAL: 3 cycles.
  - Each wait cycle adds 1.
- Back-to-back instructions: FETCH follows the retiring cycle immediately; there are no bubble cycles.
- `opcode` is sampled only in DECODE, EXEC, MEM and WB.

## Test plan
- ADDI (0010011), `mem_ready` always 1 -> states FETCH, DECODE, EXEC, WB. reg_write_en=1 only in WB. instr_retired at cycle 4; retired_count=1.
- LW (0000011), `mem_ready` low for 3 cycles in MEM -> mem_req/iord=1/mem_read_en held 4 cycles. WB has mem_to_reg=1. Total latency 8 cycles.
- BEQ with zero=0, then zero=1 -> pc_write_en=0 in EXEC, then pc_write_en=1 with pc_src=1. Each instruction retires in 3 cycles.
- Opcode 7'b1111111 -> HALT after DECODE; illegal_op=1, halted=1, retired_count unchanged. `rst` pulse clears illegal_op and fetch resumes.
- `mem_ready` held 0 in FETCH -> after 16 wait cycles, HALT with bus_err=1. Separately, `mem_ready` on the 16th wait cycle completes the fetch with no error.
- `rst` asserted during MEM of a store -> mem_write_en drops at that edge, no retire; next cycle after release is FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: per-instruction RV32I sequencer sharing one memory port between fetch and data access
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             ir_write_en,
  output logic             pc_write_en,
  output logic             pc_src,
  output logic             reg_write_en,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             jump,
  output logic             branch,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  output logic             illegal_op,
  output logic             bus_err
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, nxt;
  logic [7:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic ill, berr, run, req, tmo, retire;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, legal, is_f, is_d, is_e, is_m, is_w;
  assign is_r = opcode == 7'b0110011;
  assign is_i = opcode == 7'b0010011;
  assign is_ld = opcode == 7'b0000011;
  assign is_st = opcode == 7'b0100011;
  assign is_br = opcode == 7'b1100011;
  assign is_jal = opcode == 7'b1101111;
  assign legal = is_r | is_i | is_ld | is_st | is_br | is_jal;
  assign is_f = state == FETCH;
  assign is_d = state == DECODE;
  assign is_e = state == EXEC;
  assign is_m = state == MEM;
  assign is_w = state == WB;
  assign run = !rst;
  assign req = is_f | is_m;
  // mem_ready on the final allowed wait cycle still completes the transfer
  assign tmo = req && !mem_ready && wcnt == 8'(TIMEOUT - 1);
  assign retire = (is_e && (is_br | is_jal)) || (is_m && is_st && mem_ready) || is_w;
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = mem_ready ? DECODE : tmo ? HALT : FETCH;
      DECODE:  nxt = legal ? EXEC : HALT;
      EXEC:    nxt = (is_br | is_jal) ? FETCH : (is_ld | is_st) ? MEM : WB;
      MEM:     nxt = mem_ready ? (is_ld ? WB : FETCH) : tmo ? HALT : MEM;
      WB:      nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      wcnt <= '0;
      cnt <= '0;
      ill <= 1'b0;
      berr <= 1'b0;
    end else begin
      state <= nxt;
      wcnt <= (nxt != state) ? 8'd0 : (req && !mem_ready) ? wcnt + 8'd1 : wcnt;
      cnt <= cnt + CNT_W'(retire);
      ill <= ill | (is_d & !legal);
      berr <= berr | tmo;
    end
  end
  assign mem_req = run && req;
  assign iord = run && is_m;
  assign mem_read_en = run && (is_f || (is_m && is_ld));
  assign mem_write_en = run && is_m && is_st;
  assign ir_write_en = run && is_f && mem_ready;
  assign pc_write_en = run && ((is_f && mem_ready) || (is_e && (is_jal || (is_br && zero))));
  assign pc_src = run && is_e && (is_br || is_jal);
  assign reg_write_en = run && ((is_e && is_jal) || is_w);
  assign mem_to_reg = run && is_w && is_ld;
  assign alu_src = run && ((is_e && (is_i || is_ld || is_st)) || is_m);
  assign alu_op = !run ? 2'b00 : (is_e && is_br) ? 2'b10 : alu_src ? 2'b01 : 2'b00;
  assign jump = run && is_e && is_jal;
  assign branch = run && is_e && is_br;
  assign instr_retired = run && retire;
  assign retired_count = run ? cnt : '0;
  assign halted = run && state == HALT;
  assign illegal_op = run && ill;
  assign bus_err = run && berr;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors with a queued scoreboard checked at the falling edge
module tb_multicycle_ctrl;
  logic clk = 0, rst = 1, zero = 0, mem_ready = 0;
  logic [6:0] opcode = '0;
  logic mem_req, iord, mem_read_en, mem_write_en, ir_write_en, pc_write_en, pc_src;
  logic reg_write_en, mem_to_reg, alu_src, jump, branch, instr_retired, halted, illegal_op, bus_err;
  logic [1:0] alu_op;
  logic [31:0] retired_count;
  logic [17:0] ctl;
  int passed = 0, total = 0;
  localparam logic [17:0] REQ = 18'h20000, IORD = 18'h10000, RD = 18'h08000, WR = 18'h04000,
    IRW = 18'h02000, PCW = 18'h01000, PCS = 18'h00800, RW = 18'h00400, M2R = 18'h00200,
    ASRC = 18'h00100, OP10 = 18'h00080, OP01 = 18'h00040, JMP = 18'h00020, BR = 18'h00010,
    RET = 18'h00008, HLT = 18'h00004, ILL = 18'h00002, BERR = 18'h00001, NONE = 18'h0;
  localparam logic [17:0] F_WAIT = REQ | RD, F_GO = REQ | RD | IRW | PCW, EX_I = ASRC | OP01,
    EX_BR0 = BR | OP10 | PCS | RET, EX_BR1 = BR | OP10 | PCS | RET | PCW,
    EX_JAL = JMP | PCS | PCW | RW | RET, M_LD = REQ | IORD | OP01 | ASRC | RD,
    M_ST = REQ | IORD | OP01 | ASRC | WR, WB_LD = RW | M2R | RET, WB_A = RW | RET;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
    BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
  typedef struct {
    string name;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .ir_write_en(ir_write_en), .pc_write_en(pc_write_en), .pc_src(pc_src),
    .reg_write_en(reg_write_en), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .jump(jump), .branch(branch), .instr_retired(instr_retired), .retired_count(retired_count),
    .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  assign ctl = {mem_req, iord, mem_read_en, mem_write_en, ir_write_en, pc_write_en, pc_src,
                reg_write_en, mem_to_reg, alu_src, alu_op, jump, branch, instr_retired,
                halted, illegal_op, bus_err};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      total += 2;
      if (ctl === e.ctl) passed++;
      else $display("FAIL %s ctl got %b want %b", e.name, ctl, e.ctl);
      if (retired_count === e.cnt) passed++;
      else $display("FAIL %s retired_count got %0d want %0d", e.name, retired_count, e.cnt);
    end
  end

  task automatic cyc(input string n, input logic r, input logic [6:0] op, input logic z,
                     input logic rdy, input logic [17:0] c, input logic [31:0] k);
    rst = r; opcode = op; zero = z; mem_ready = rdy;
    q.push_back('{n, c, k});
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    cyc("rst0", 1, I, 0, 1, NONE, 0);
    cyc("rst1", 1, I, 0, 1, NONE, 0);
    cyc("addi_f", 0, I, 0, 1, F_GO, 0);
    cyc("addi_d", 0, I, 0, 1, NONE, 0);
    cyc("addi_e", 0, I, 0, 1, EX_I, 0);
    cyc("addi_wb", 0, I, 0, 1, WB_A, 0);
    cyc("lw_f", 0, LD, 0, 1, F_GO, 1);
    cyc("lw_d", 0, LD, 0, 1, NONE, 1);
    cyc("lw_e", 0, LD, 0, 1, EX_I, 1);
    for (int i = 0; i < 3; i++) cyc("lw_mwait", 0, LD, 0, 0, M_LD, 1);
    cyc("lw_mgo", 0, LD, 0, 1, M_LD, 1);
    cyc("lw_wb", 0, LD, 0, 1, WB_LD, 1);
    cyc("beq0_f", 0, BQ, 0, 1, F_GO, 2);
    cyc("beq0_d", 0, BQ, 0, 1, NONE, 2);
    cyc("beq0_e", 0, BQ, 0, 1, EX_BR0, 2);
    cyc("beq1_f", 0, BQ, 1, 1, F_GO, 3);
    cyc("beq1_d", 0, BQ, 1, 1, NONE, 3);
    cyc("beq1_e", 0, BQ, 1, 1, EX_BR1, 3);
    cyc("jal_f", 0, JL, 0, 1, F_GO, 4);
    cyc("jal_d", 0, JL, 0, 1, NONE, 4);
    cyc("jal_e", 0, JL, 0, 1, EX_JAL, 4);
    cyc("add_f", 0, R, 0, 1, F_GO, 5);
    cyc("add_d", 0, R, 0, 1, NONE, 5);
    cyc("add_e", 0, R, 0, 1, NONE, 5);
    cyc("add_wb", 0, R, 0, 1, WB_A, 5);
    cyc("sw_f", 0, ST, 0, 1, F_GO, 6);
    cyc("sw_d", 0, ST, 0, 1, NONE, 6);
    cyc("sw_e", 0, ST, 0, 1, EX_I, 6);
    cyc("sw_mwait", 0, ST, 0, 0, M_ST, 6);
    cyc("sw_mgo", 0, ST, 0, 1, M_ST | RET, 6);
    for (int i = 0; i < 15; i++) cyc("fwait15", 0, I, 0, 0, F_WAIT, 7);
    cyc("fgo_last", 0, I, 0, 1, F_GO, 7);
    cyc("late_d", 0, I, 0, 1, NONE, 7);
    cyc("late_e", 0, I, 0, 1, EX_I, 7);
    cyc("late_wb", 0, I, 0, 1, WB_A, 7);
    cyc("ill_f", 0, BAD, 0, 1, F_GO, 8);
    cyc("ill_d", 0, BAD, 0, 1, NONE, 8);
    cyc("ill_h0", 0, BAD, 0, 1, HLT | ILL, 8);
    cyc("ill_h1", 0, BAD, 0, 1, HLT | ILL, 8);
    cyc("ill_rst", 1, BAD, 0, 1, NONE, 0);
    cyc("resume_f", 0, ST, 0, 1, F_GO, 0);
    cyc("rsw_d", 0, ST, 0, 1, NONE, 0);
    cyc("rsw_e", 0, ST, 0, 1, EX_I, 0);
    cyc("rsw_mwait", 0, ST, 0, 0, M_ST, 0);
    cyc("rsw_rst", 1, ST, 0, 1, NONE, 0);
    for (int i = 0; i < 16; i++) cyc("to_wait", 0, I, 0, 0, F_WAIT, 0);
    cyc("to_h0", 0, I, 0, 1, HLT | BERR, 0);
    cyc("to_h1", 0, I, 0, 1, HLT | BERR, 0);
    cyc("to_rst", 1, I, 0, 1, NONE, 0);
    cyc("to_resume", 0, I, 0, 1, F_GO, 0);
    repeat (4) if (q.size() > 0) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
